// File: rtl/path_pulse_scheduler.sv
// path_pulse_scheduler
//
// Delays each edge of a single-bit source by a run-time programmable
// rise/fall delay and applies pulse-limit handling to the result. Narrow
// pulses are rejected, turned into X, or (negative width) dropped or shown
// as X. Pending events live in a two-slot queue (HEAD, TAIL). Each slot
// carries the value to drive, a countdown to maturity, an X mark, and the
// slot age, which is the pulse width seen by the next edge.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_sig      source signal, sampled on clk
//   rise_dly    delay applied to a 0->1 edge (cycles)
//   fall_dly    delay applied to a 1->0 edge (cycles)
//   reject_lim  pulses narrower than this are discarded
//   error_lim   pulses narrower than this, but not rejected, become X
//   ondetect    1: X shown one cycle after detection; 0: X shown when the event matures
//   showcancel  1: negative-width pulses shown as X; 0: dropped silently
//   out_sig     delayed output value
//   out_x       output is in the X state
//   rej_p       one-cycle strobe, pulse rejected
//   err_p       one-cycle strobe, pulse converted to X
//   ovf_p       one-cycle strobe, edge dropped because the queue was full
//   busy        at least one event was pending in the previous cycle
module path_pulse_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_sig,
    input  logic [CNT_W-1:0] rise_dly,
    input  logic [CNT_W-1:0] fall_dly,
    input  logic [CNT_W-1:0] reject_lim,
    input  logic [CNT_W-1:0] error_lim,
    input  logic             ondetect,
    input  logic             showcancel,
    output logic             out_sig,
    output logic             out_x,
    output logic             rej_p,
    output logic             err_p,
    output logic             ovf_p,
    output logic             busy
);
    typedef enum logic [1:0] {Q_EMPTY = 2'd0, Q_ONE = 2'd1, Q_TWO = 2'd2} q_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] a);
        return (a == CNT_MAX) ? a : a + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] dec_floor(input logic [CNT_W-1:0] a);
        return (a == '0) ? a : a - 1'b1;
    endfunction

    q_state_t         q_state, q_state_n, m_state;
    logic             in_prev;
    logic             hd_val, hd_xm, tl_val, tl_xm;
    logic [CNT_W-1:0] hd_cnt, hd_age, tl_cnt, tl_age;
    logic             hd_val_n, hd_xm_n, tl_val_n, tl_xm_n;
    logic [CNT_W-1:0] hd_cnt_n, hd_age_n, tl_cnt_n, tl_age_n;
    logic             m_hd_val, m_hd_xm, m_tl_val, m_tl_xm;
    logic [CNT_W-1:0] m_hd_cnt, m_hd_age, m_tl_cnt, m_tl_age;
    logic             edge_det, mature;
    logic [CNT_W-1:0] edge_dly;
    logic             rej_hit, err_hit, ovf_hit, xset_hit;
    logic             rej_p0, err_p0, ovf_p0, xset_p0;
    logic             out_sig_n, out_x_n, busy_n;

    // State register: control state carries the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_state <= Q_EMPTY;
            in_prev <= 1'b0;
            out_sig <= 1'b0;
            out_x   <= 1'b0;
            rej_p0  <= 1'b0;
            err_p0  <= 1'b0;
            ovf_p0  <= 1'b0;
            xset_p0 <= 1'b0;
            rej_p   <= 1'b0;
            err_p   <= 1'b0;
            ovf_p   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            q_state <= q_state_n;
            in_prev <= in_sig;
            out_sig <= out_sig_n;
            out_x   <= out_x_n;
            rej_p0  <= rej_hit;
            err_p0  <= err_hit;
            ovf_p0  <= ovf_hit;
            xset_p0 <= xset_hit;
            rej_p   <= rej_p0;
            err_p   <= err_p0;
            ovf_p   <= ovf_p0;
            busy    <= busy_n;
        end
    end

    // Slot payloads are only meaningful while q_state marks them occupied
    always_ff @(posedge clk) begin
        hd_val <= hd_val_n;
        hd_xm  <= hd_xm_n;
        hd_cnt <= hd_cnt_n;
        hd_age <= hd_age_n;
        tl_val <= tl_val_n;
        tl_xm  <= tl_xm_n;
        tl_cnt <= tl_cnt_n;
        tl_age <= tl_age_n;
    end

    // Next-state: age the queue, pop a matured HEAD, then judge the edge
    always_comb begin
        edge_det = (in_sig != in_prev);
        edge_dly = in_sig ? rise_dly : fall_dly;
        mature   = (q_state != Q_EMPTY) && (hd_cnt == '0);

        m_state  = q_state;
        m_tl_val = tl_val;
        m_tl_xm  = tl_xm;
        m_tl_cnt = dec_floor(tl_cnt);
        m_tl_age = inc_sat(tl_age);
        m_hd_val = hd_val;
        m_hd_xm  = hd_xm;
        m_hd_cnt = dec_floor(hd_cnt);
        m_hd_age = inc_sat(hd_age);
        if (mature) begin
            if (q_state == Q_TWO) begin
                m_state  = Q_ONE;
                m_hd_val = m_tl_val;
                m_hd_xm  = m_tl_xm;
                m_hd_cnt = m_tl_cnt;
                m_hd_age = m_tl_age;
            end else begin
                m_state = Q_EMPTY;
            end
        end

        q_state_n = m_state;
        hd_val_n  = m_hd_val;
        hd_xm_n   = m_hd_xm;
        hd_cnt_n  = m_hd_cnt;
        hd_age_n  = m_hd_age;
        tl_val_n  = m_tl_val;
        tl_xm_n   = m_tl_xm;
        tl_cnt_n  = m_tl_cnt;
        tl_age_n  = m_tl_age;
        rej_hit   = 1'b0;
        err_hit   = 1'b0;
        ovf_hit   = 1'b0;
        xset_hit  = 1'b0;

        if (edge_det) begin
            case (m_state)
                Q_EMPTY: begin
                    q_state_n = Q_ONE;
                    hd_val_n  = in_sig;
                    hd_xm_n   = 1'b0;
                    hd_cnt_n  = edge_dly;
                    hd_age_n  = '0;
                end
                Q_ONE: begin
                    if (m_hd_age < reject_lim) begin
                        q_state_n = Q_EMPTY;
                        rej_hit   = 1'b1;
                    end else if (edge_dly <= m_hd_cnt) begin
                        // New edge would mature no later than HEAD: negative width
                        if (showcancel) begin
                            q_state_n = Q_TWO;
                            hd_xm_n   = 1'b1;
                            tl_val_n  = in_sig;
                            tl_xm_n   = 1'b0;
                            tl_cnt_n  = inc_sat(m_hd_cnt);
                            tl_age_n  = '0;
                            err_hit   = 1'b1;
                        end else begin
                            q_state_n = Q_EMPTY;
                            rej_hit   = 1'b1;
                        end
                    end else begin
                        q_state_n = Q_TWO;
                        tl_val_n  = in_sig;
                        tl_xm_n   = 1'b0;
                        tl_cnt_n  = edge_dly;
                        tl_age_n  = '0;
                        // Error band is empty whenever error_lim <= reject_lim
                        if (m_hd_age < error_lim) begin
                            hd_xm_n  = 1'b1;
                            err_hit  = 1'b1;
                            xset_hit = ondetect;
                        end
                    end
                end
                Q_TWO: begin
                    if (m_tl_age < reject_lim) begin
                        q_state_n = Q_ONE;
                        rej_hit   = 1'b1;
                    end else begin
                        ovf_hit = 1'b1;
                    end
                end
                default: begin
                    q_state_n = Q_EMPTY;
                end
            endcase
        end
    end

    // Output: matured value, X from the popped mark or from on-detect
    always_comb begin
        out_sig_n = out_sig;
        out_x_n   = out_x;
        if (mature) begin
            out_sig_n = hd_val;
            out_x_n   = hd_xm;
        end
        if (xset_p0) begin
            out_x_n = 1'b1;
        end
        busy_n = (q_state != Q_EMPTY);
    end

endmodule

// File: tb/tb_path_pulse_scheduler.sv
`timescale 1ns/1ps
module tb_path_pulse_scheduler;
    localparam int CNT_W = 8;
    localparam int NCYC  = 24;
    localparam int NVEC  = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_sig = 1'b0;
    logic [CNT_W-1:0] rise_dly = '0;
    logic [CNT_W-1:0] fall_dly = '0;
    logic [CNT_W-1:0] reject_lim = '0;
    logic [CNT_W-1:0] error_lim = '0;
    logic             ondetect = 1'b0;
    logic             showcancel = 1'b0;
    logic             out_sig, out_x, rej_p, err_p, ovf_p, busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    path_pulse_scheduler #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sig     (in_sig),
        .rise_dly   (rise_dly),
        .fall_dly   (fall_dly),
        .reject_lim (reject_lim),
        .error_lim  (error_lim),
        .ondetect   (ondetect),
        .showcancel (showcancel),
        .out_sig    (out_sig),
        .out_x      (out_x),
        .rej_p      (rej_p),
        .err_p      (err_p),
        .ovf_p      (ovf_p),
        .busy       (busy)
    );

    // Edge times and expected windows are cycle indices counted from the
    // first posedge after reset release; [s, e) windows, -1 means never.
    typedef struct {
        string name;
        int    rise_d, fall_d, rlim, elim;
        bit    ondet, showc;
        int    e1, e2, e3;
        int    hi_s, hi_e, x_s, x_e;
        int    rej_at, err_at, ovf_at;
        int    busy_s, busy_e;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(input string nm,
                                input int rd, input int fd, input int rl, input int el,
                                input bit od, input bit sc,
                                input int e1, input int e2, input int e3,
                                input int hs, input int he, input int xs, input int xe,
                                input int ra, input int ea, input int oa,
                                input int bs, input int be);
        vec_t v;
        v.name = nm;   v.rise_d = rd; v.fall_d = fd; v.rlim = rl; v.elim = el;
        v.ondet = od;  v.showc = sc;
        v.e1 = e1;     v.e2 = e2;     v.e3 = e3;
        v.hi_s = hs;   v.hi_e = he;   v.x_s = xs;    v.x_e = xe;
        v.rej_at = ra; v.err_at = ea; v.ovf_at = oa;
        v.busy_s = bs; v.busy_e = be;
        return v;
    endfunction

    task automatic chk(input string nm, input int k, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", nm, k, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm, input int k);
        chk({nm, " out_sig"}, k, out_sig, 1'b0);
        chk({nm, " out_x"},   k, out_x,   1'b0);
        chk({nm, " rej_p"},   k, rej_p,   1'b0);
        chk({nm, " err_p"},   k, err_p,   1'b0);
        chk({nm, " ovf_p"},   k, ovf_p,   1'b0);
        chk({nm, " busy"},    k, busy,    1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        logic lvl;
        rst_n      = 1'b0;
        in_sig     = 1'b0;
        rise_dly   = CNT_W'(v.rise_d);
        fall_dly   = CNT_W'(v.fall_d);
        reject_lim = CNT_W'(v.rlim);
        error_lim  = CNT_W'(v.elim);
        ondetect   = v.ondet;
        showcancel = v.showc;
        @(posedge clk); #1;
        chk_all_zero({v.name, " reset"}, -1);
        rst_n = 1'b1;
        lvl   = 1'b0;
        for (int k = 0; k < NCYC; k++) begin
            if (k == v.e1 || k == v.e2 || k == v.e3) lvl = ~lvl;
            in_sig = lvl;
            @(posedge clk); #1;
            chk({v.name, " out_sig"}, k, out_sig, (k >= v.hi_s && k < v.hi_e));
            chk({v.name, " out_x"},   k, out_x,   (k >= v.x_s && k < v.x_e));
            chk({v.name, " rej_p"},   k, rej_p,   (k == v.rej_at));
            chk({v.name, " err_p"},   k, err_p,   (k == v.err_at));
            chk({v.name, " ovf_p"},   k, ovf_p,   (k == v.ovf_at));
            chk({v.name, " busy"},    k, busy,    (k >= v.busy_s && k < v.busy_e));
        end
    endtask

    initial begin
        //                 name        rd  fd rl el od sc  e1  e2  e3  hi_s hi_e x_s x_e rej err ovf  bs  be
        tbl[0] = mk("dly3",         3,  3, 0, 0, 0, 0,  5, -1, -1,   9,  99, -1, -1, -1, -1, -1,  6, 10);
        tbl[1] = mk("reject",       6,  6, 2, 0, 0, 0,  5,  6, -1,  -1,  -1, -1, -1,  7, -1, -1,  6,  7);
        tbl[2] = mk("err_event",    6,  6, 2, 5, 0, 0,  5,  8, -1,  12,  15, 12, 15, -1,  9, -1,  6, 16);
        tbl[3] = mk("err_detect",   6,  6, 2, 5, 1, 0,  5,  8, -1,  12,  15,  9, 15, -1,  9, -1,  6, 16);
        tbl[4] = mk("neg_drop",     8,  2, 0, 0, 0, 0,  5,  8, -1,  -1,  -1, -1, -1,  9, -1, -1,  6,  9);
        tbl[5] = mk("neg_show",     8,  2, 0, 0, 0, 1,  5,  8, -1,  14,  15, 14, 15, -1,  9, -1,  6, 16);
        tbl[6] = mk("overflow",    10, 10, 0, 0, 0, 0,  5,  7,  9,  16,  18, -1, -1, -1, -1, 10,  6, 19);
        tbl[7] = mk("rej_tail",    10, 10, 2, 2, 0, 0,  5,  8,  9,  16,  99, -1, -1, 10, -1, -1,  6, 17);
        tbl[8] = mk("dly0",         0,  0, 0, 0, 0, 0,  5, -1, -1,   6,  99, -1, -1, -1, -1, -1,  6,  7);
        tbl[9] = mk("mature_edge",  2,  2, 0, 0, 0, 0,  5,  8, -1,   8,  11, -1, -1, -1, -1, -1,  6, 12);

        for (int i = 0; i < NVEC; i++) run_vec(tbl[i]);

        // Reset with both slots full and out_x already set on detection
        rst_n      = 1'b0;
        in_sig     = 1'b0;
        rise_dly   = 8'd10;
        fall_dly   = 8'd10;
        reject_lim = 8'd0;
        error_lim  = 8'd5;
        ondetect   = 1'b1;
        showcancel = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 5) in_sig = 1'b1;
            if (k == 8) in_sig = 1'b0;
            @(posedge clk); #1;
            if (k == 9) begin
                chk("mid_reset setup out_x", k, out_x, 1'b1);
                chk("mid_reset setup busy",  k, busy,  1'b1);
                chk("mid_reset setup err_p", k, err_p, 1'b1);
            end
        end
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset immediate", 10);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 13; k < 33; k++) begin
            @(posedge clk); #1;
            chk_all_zero("after_reset", k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
